// File: rtl/tone_gen_multi_if.sv
// Port bundle of the multi-channel tone generator: divisors and key gates in,
// square waves, beeper stream and running-channel count out.
interface tone_gen_multi_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
);
  localparam int CW = $clog2(NCH + 1);

  logic [NCH*WIDTH-1:0] div;
  logic [NCH-1:0]       gate;
  logic [NCH-1:0]       tone;
  logic                 beep;
  logic [CW-1:0]        active_cnt;

  modport master (output div, gate, input tone, beep, active_cnt);
  modport slave  (input div, gate, output tone, beep, active_cnt);
endinterface

// File: rtl/tone_gen_multi.sv
// NCH independent square-wave dividers with click-free key release, mixed into
// one first-order sigma-delta bit for the beeper.
module tone_gen_multi #(
  parameter int WIDTH             = 32,
  parameter int NCH               = 4,
  parameter bit RESTART_ON_CHANGE = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  tone_gen_multi_if.slave bus
);
  localparam int CW = $clog2(NCH + 1);
  localparam int AW = CW + 1;

  logic [NCH-1:0] tone_vec;
  logic [NCH-1:0] run_vec;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cur_div_reg;
    logic [WIDTH-1:0] prev_div_reg;
    logic             run_reg;
    logic             tone_reg;
    logic [WIDTH-1:0] div_in;
    logic             at_end;

    assign div_in   = bus.div[gi*WIDTH +: WIDTH];
    // Compare against the latched divisor so a live div change cannot
    // shorten or stretch the phase in progress.
    assign at_end   = (cnt_reg == cur_div_reg - WIDTH'(1));
    assign tone_vec[gi] = tone_reg;
    assign run_vec[gi]  = run_reg;

    always_ff @(posedge clk) begin
      if (rst_n) begin
        cnt_reg      <= '0;
        cur_div_reg  <= '0;
        prev_div_reg <= '0;
        run_reg      <= 1'b0;
        tone_reg     <= 1'b0;
      end else begin
        prev_div_reg <= div_in;
        if (div_in == '0) begin
          tone_reg    <= 1'b0;
          cnt_reg     <= '0;
          run_reg     <= 1'b0;
          cur_div_reg <= '0;
        end else if (bus.gate[gi] && !run_reg) begin
          run_reg     <= 1'b1;
          cnt_reg     <= '0;
          cur_div_reg <= div_in;
        end else if (!bus.gate[gi] && run_reg) begin
          // Released key: a high phase always runs to its natural falling edge.
          if (!tone_reg) begin
            run_reg <= 1'b0;
            cnt_reg <= '0;
          end else if (at_end) begin
            run_reg  <= 1'b0;
            cnt_reg  <= '0;
            tone_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + WIDTH'(1);
          end
        end else if (RESTART_ON_CHANGE && run_reg && (div_in != prev_div_reg)) begin
          cnt_reg     <= '0;
          cur_div_reg <= div_in;
        end else if (run_reg) begin
          if (at_end) begin
            cnt_reg  <= '0;
            tone_reg <= ~tone_reg;
            if (!RESTART_ON_CHANGE) begin
              cur_div_reg <= div_in;
            end
          end else begin
            cnt_reg <= cnt_reg + WIDTH'(1);
          end
        end
      end
    end
  end

  logic [CW-1:0] tone_pop;
  logic [CW-1:0] run_pop;
  logic [CW-1:0] sum_reg;
  logic [CW-1:0] active_cnt_reg;
  logic [AW-1:0] acc_reg;
  logic [AW-1:0] acc_t;
  logic          beep_reg;

  always_comb begin
    tone_pop = '0;
    run_pop  = '0;
    for (int i = 0; i < NCH; i++) begin
      tone_pop = tone_pop + CW'(tone_vec[i]);
      run_pop  = run_pop + CW'(run_vec[i]);
    end
    acc_t = acc_reg + AW'(sum_reg);
  end

  // acc stays below NCH, so acc + sum < 2*NCH always fits in AW bits.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sum_reg        <= '0;
      active_cnt_reg <= '0;
      acc_reg        <= '0;
      beep_reg       <= 1'b0;
    end else begin
      sum_reg        <= tone_pop;
      active_cnt_reg <= run_pop;
      if (acc_t >= AW'(NCH)) begin
        beep_reg <= 1'b1;
        acc_reg  <= acc_t - AW'(NCH);
      end else begin
        beep_reg <= 1'b0;
        acc_reg  <= acc_t;
      end
    end
  end

  assign bus.tone       = tone_vec;
  assign bus.beep       = beep_reg;
  assign bus.active_cnt = active_cnt_reg;
endmodule

// File: tb/tb_tone_gen_multi.sv
// Directed bench: single-channel timing, release, divisor-change modes and
// edge divisors on 8-bit channels; mixing and mid-note reset on four channels.
module tb_tone_gen_multi;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tone_gen_multi_if #(.WIDTH(8), .NCH(1))  if_a ();
  tone_gen_multi_if #(.WIDTH(8), .NCH(1))  if_b ();
  tone_gen_multi_if #(.WIDTH(32), .NCH(4)) if_m ();

  tone_gen_multi #(.WIDTH(8), .NCH(1), .RESTART_ON_CHANGE(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  tone_gen_multi #(.WIDTH(8), .NCH(1), .RESTART_ON_CHANGE(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));
  tone_gen_multi #(.WIDTH(32), .NCH(4), .RESTART_ON_CHANGE(1'b1)) u_m (
    .clk(clk), .rst_n(rst_n), .bus(if_m));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int popsum;
    int beeps;
    int ch3_ones;

    if_a.div = '0; if_a.gate = '0;
    if_b.div = '0; if_b.gate = '0;
    if_m.div = '0; if_m.gate = '0;
    ticks(2);
    rst_n = 1'b0;
    tick();
    check("rst_a_tone", 64'(if_a.tone), 64'd0);
    check("rst_a_beep", 64'(if_a.beep), 64'd0);
    check("rst_a_act", 64'(if_a.active_cnt), 64'd0);
    check("rst_m_tone", 64'(if_m.tone), 64'd0);
    check("rst_m_act", 64'(if_m.active_cnt), 64'd0);

    // Single tone, div=5
    if_a.div = 8'd5; if_a.gate = 1'b1;
    tick();
    check("st_tone_e0", 64'(if_a.tone), 64'd0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      check($sformatf("st_tone_k%0d", k), 64'(if_a.tone), 64'((k / 5) % 2));
      check($sformatf("st_beep_k%0d", k), 64'(if_a.beep), (k >= 2) ? 64'(((k - 2) / 5) % 2) : 64'd0);
      check($sformatf("st_act_k%0d", k), 64'(if_a.active_cnt), 64'd1);
    end

    // Click-free release, div=8, gate dropped 2 cycles after the rise
    if_a.gate = 1'b0; if_a.div = '0;
    ticks(2);
    check("rel_idle_act", 64'(if_a.active_cnt), 64'd0);
    if_a.div = 8'd8; if_a.gate = 1'b1;
    tick();
    ticks(7);
    check("rel_tone_k7", 64'(if_a.tone), 64'd0);
    tick();
    check("rel_tone_rise", 64'(if_a.tone), 64'd1);
    tick();
    if_a.gate = 1'b0;
    for (int k = 10; k <= 15; k++) begin
      tick();
      check($sformatf("rel_hold_k%0d", k), 64'(if_a.tone), 64'd1);
    end
    tick();
    check("rel_fall_tone", 64'(if_a.tone), 64'd0);
    check("rel_fall_act", 64'(if_a.active_cnt), 64'd1);
    tick();
    check("rel_act_zero", 64'(if_a.active_cnt), 64'd0);
    ticks(10);
    check("rel_silent_tone", 64'(if_a.tone), 64'd0);
    check("rel_silent_act", 64'(if_a.active_cnt), 64'd0);

    // Divisor change 10 -> 4 mid high phase, both policies
    if_a.div = '0; if_b.div = '0;
    ticks(2);
    if_a.div = 8'd10; if_a.gate = 1'b1;
    if_b.div = 8'd10; if_b.gate = 1'b1;
    tick();
    ticks(10);
    check("chg_a_rise", 64'(if_a.tone), 64'd1);
    check("chg_b_rise", 64'(if_b.tone), 64'd1);
    ticks(2);
    if_a.div = 8'd4; if_b.div = 8'd4;
    for (int k = 13; k <= 32; k++) begin
      tick();
      check($sformatf("chg_restart_k%0d", k), 64'(if_a.tone),
            (k < 17) ? 64'd1 : ((((k - 17) / 4) % 2) == 0 ? 64'd0 : 64'd1));
      check($sformatf("chg_defer_k%0d", k), 64'(if_b.tone),
            (k < 20) ? 64'd1 : ((((k - 20) / 4) % 2) == 0 ? 64'd0 : 64'd1));
    end
    if_a.gate = 1'b0; if_a.div = '0;
    if_b.gate = 1'b0; if_b.div = '0;
    ticks(2);

    // Edge divisors on 8-bit channel: 1 and 255
    if_a.div = 8'd1; if_a.gate = 1'b1;
    tick();
    check("d1_e0", 64'(if_a.tone), 64'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("d1_k%0d", k), 64'(if_a.tone), 64'(k % 2));
    end
    if_a.gate = 1'b0; if_a.div = '0;
    ticks(2);
    if_a.div = 8'd255; if_a.gate = 1'b1;
    tick();
    ticks(254);
    check("dmax_k254", 64'(if_a.tone), 64'd0);
    tick();
    check("dmax_k255", 64'(if_a.tone), 64'd1);
    ticks(254);
    check("dmax_k509", 64'(if_a.tone), 64'd1);
    tick();
    check("dmax_k510", 64'(if_a.tone), 64'd0);
    ticks(254);
    check("dmax_k764", 64'(if_a.tone), 64'd0);
    tick();
    check("dmax_k765", 64'(if_a.tone), 64'd1);
    if_a.gate = 1'b0; if_a.div = '0;
    ticks(2);

    // Mix density: channels at div 1,3,7 and channel 3 silent
    if_m.div = {32'd0, 32'd7, 32'd3, 32'd1};
    if_m.gate = 4'hF;
    popsum = 0; beeps = 0; ch3_ones = 0;
    tick();
    for (int k = 0; k <= 4201; k++) begin
      if (k > 0) tick();
      if (k < 4200) begin
        popsum += $countones(if_m.tone);
        ch3_ones += int'(if_m.tone[3]);
      end
      if (k >= 2) beeps += int'(if_m.beep);
    end
    check("mix_popsum", 64'(popsum), 64'd6300);
    check("mix_beeps_in_range", 64'((beeps >= 1574) && (beeps <= 1576)), 64'd1);
    check("mix_ch3_never_high", 64'(ch3_ones), 64'd0);
    check("mix_active", 64'(if_m.active_cnt), 64'd3);

    // Reset mid-operation
    rst_n = 1'b1;
    tick();
    check("mrst_tone", 64'(if_m.tone), 64'd0);
    check("mrst_beep", 64'(if_m.beep), 64'd0);
    check("mrst_act", 64'(if_m.active_cnt), 64'd0);
    if_m.gate = 4'h0;
    tick();
    rst_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("post_rst_tone_%0d", k), 64'(if_m.tone), 64'd0);
      check($sformatf("post_rst_act_%0d", k), 64'(if_m.active_cnt), 64'd0);
    end
    if_m.gate = 4'b0001;
    tick();
    check("regate_e0_tone", 64'(if_m.tone), 64'd0);
    tick();
    check("regate_e1_tone", 64'(if_m.tone), 64'b0001);
    check("regate_e1_act", 64'(if_m.active_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
